// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI/local RAM arbiter.
//   - SPI opcode constants (bits [9:8] of the SPI command word)
//   - Controller FSM state encoding
//   - Grant-source encoding and grant-vector bit positions
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2
    } state_e;

    // Grant source; the value doubles as the requester index in the arbiter.
    typedef enum logic {
        SRC_SPI = 1'b0,
        SRC_LOC = 1'b1
    } src_e;

    localparam int GNT_SPI = 0;
    localparam int GNT_LOC = 1;

endpackage

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, rst  : clock and synchronous active-high reset
//   req[1:0]  : request vector (bit i = requester i)
//   upd       : record upd_idx as the most recent grant
//   upd_idx   : index of the requester that was just served
//   gnt[1:0]  : combinational one-hot grant
// When both request, the requester that was not served last wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_idx,
    output logic [1:0] gnt
);

    logic last_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg <= 1'b0;
        end else if (upd) begin
            last_reg <= upd_idx;
        end
    end

    // A requester wins if it is alone, or if the other one was served last.
    for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
        assign gnt[gi] = req[gi] && (!req[1-gi] || (last_reg != 1'(gi)));
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// SPI command decoder and RAM access arbiter.
// Decodes 10-bit SPI command words (address load / write data / read data),
// and shares a single-port synchronous RAM round-robin between the SPI path
// and a local request port.
//   clk, rst                 : clock, synchronous active-high reset
//   spi_rx_data/_valid       : SPI command word and its level-valid
//   spi_tx_data/_valid       : SPI read data, held until the next accepted word
//   spi_err                  : sticky, an SPI data command was dropped
//   loc_req/we/addr/wdata    : local request port (held until loc_gnt)
//   loc_gnt                  : one-cycle pulse when the local access issues
//   loc_rdata/loc_rvalid     : local read data and its one-cycle qualifier
//   ram_en/we/addr/wdata     : RAM command, all registered
//   ram_rdata                : RAM read data, valid the cycle after a read
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        spi_rx_data,
    input  logic              spi_rx_valid,
    output logic [7:0]        spi_tx_data,
    output logic              spi_tx_valid,
    output logic              spi_err,
    input  logic              loc_req,
    input  logic              loc_we,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [DATA_W-1:0] loc_wdata,
    output logic              loc_gnt,
    output logic [DATA_W-1:0] loc_rdata,
    output logic              loc_rvalid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    // ---------------- SPI command decode ----------------
    logic              rx_valid_d_reg;
    logic              rx_edge;
    logic [1:0]        opcode;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic              spi_pend_reg;
    logic              spi_pend_we_reg;
    logic [ADDR_W-1:0] spi_pend_addr_reg;
    logic [DATA_W-1:0] spi_pend_wdata_reg;
    logic              spi_err_reg;
    logic              spi_clr;
    logic              spi_busy;

    state_e            state_reg, state_next;
    src_e              src_reg, src_next;
    logic              is_read_reg, is_read_next;
    logic [1:0]        arb_req;
    logic [1:0]        arb_gnt;

    logic              ram_en_reg, ram_en_next;
    logic              ram_we_reg, ram_we_next;
    logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
    logic [DATA_W-1:0] ram_wdata_reg, ram_wdata_next;
    logic              loc_gnt_reg, loc_gnt_next;
    logic [DATA_W-1:0] loc_rdata_reg, loc_rdata_next;
    logic              loc_rvalid_reg, loc_rvalid_next;
    logic [7:0]        tx_data_reg, tx_data_next;
    logic              tx_valid_reg, tx_valid_next;

    assign rx_edge = spi_rx_valid && !rx_valid_d_reg;
    assign opcode  = spi_rx_data[9:8];

    // The pending SPI op is retired in ISSUE; a new data command arriving in
    // that same cycle takes the freed slot instead of being dropped.
    assign spi_clr  = (state_reg == ISSUE) && (src_reg == SRC_SPI);
    assign spi_busy = spi_pend_reg && !spi_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid_d_reg     <= 1'b0;
            wr_addr_reg        <= '0;
            rd_addr_reg        <= '0;
            spi_pend_reg       <= 1'b0;
            spi_pend_we_reg    <= 1'b0;
            spi_pend_addr_reg  <= '0;
            spi_pend_wdata_reg <= '0;
            spi_err_reg        <= 1'b0;
        end else begin
            rx_valid_d_reg <= spi_rx_valid;
            if (spi_clr) begin
                spi_pend_reg <= 1'b0;
            end
            if (rx_edge) begin
                case (opcode)
                    CMD_WR_ADDR: wr_addr_reg <= spi_rx_data[ADDR_W-1:0];
                    CMD_RD_ADDR: rd_addr_reg <= spi_rx_data[ADDR_W-1:0];
                    default: begin
                        if (spi_busy) begin
                            spi_err_reg <= 1'b1;
                        end else begin
                            // Address is latched now so later address loads
                            // do not retarget an op already queued.
                            spi_pend_reg       <= 1'b1;
                            spi_pend_we_reg    <= (opcode == CMD_WR_DATA);
                            spi_pend_addr_reg  <= (opcode == CMD_WR_DATA) ? wr_addr_reg : rd_addr_reg;
                            spi_pend_wdata_reg <= spi_rx_data[DATA_W-1:0];
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- Arbitration ----------------
    assign arb_req = (state_reg == ARB) ? {loc_req, spi_pend_reg} : 2'b00;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .upd     (state_reg == ISSUE),
        .upd_idx (src_reg),
        .gnt     (arb_gnt)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ARB;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB:     if (|arb_gnt) state_next = ISSUE;
            ISSUE:   state_next = is_read_reg ? RD_WAIT : ARB;
            RD_WAIT: state_next = ARB;
            default: state_next = ARB;
        endcase
    end

    // ---------------- FSM: outputs (next values of registered outputs) ----------------
    always_comb begin
        ram_en_next     = 1'b0;
        ram_we_next     = ram_we_reg;
        ram_addr_next   = ram_addr_reg;
        ram_wdata_next  = ram_wdata_reg;
        loc_gnt_next    = 1'b0;
        loc_rdata_next  = loc_rdata_reg;
        loc_rvalid_next = 1'b0;
        tx_data_next    = tx_data_reg;
        tx_valid_next   = rx_edge ? 1'b0 : tx_valid_reg;
        src_next        = src_reg;
        is_read_next    = is_read_reg;
        case (state_reg)
            ARB: begin
                if (arb_gnt[GNT_LOC]) begin
                    ram_en_next    = 1'b1;
                    ram_we_next    = loc_we;
                    ram_addr_next  = loc_addr;
                    ram_wdata_next = loc_wdata;
                    loc_gnt_next   = 1'b1;
                    src_next       = SRC_LOC;
                    is_read_next   = !loc_we;
                end else if (arb_gnt[GNT_SPI]) begin
                    ram_en_next    = 1'b1;
                    ram_we_next    = spi_pend_we_reg;
                    ram_addr_next  = spi_pend_addr_reg;
                    ram_wdata_next = spi_pend_wdata_reg;
                    src_next       = SRC_SPI;
                    is_read_next   = !spi_pend_we_reg;
                end
            end
            RD_WAIT: begin
                // A read result landing with a new SPI word still sets valid.
                if (src_reg == SRC_SPI) begin
                    tx_data_next  = ram_rdata;
                    tx_valid_next = 1'b1;
                end else begin
                    loc_rdata_next  = ram_rdata;
                    loc_rvalid_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_en_reg     <= 1'b0;
            ram_we_reg     <= 1'b0;
            ram_addr_reg   <= '0;
            ram_wdata_reg  <= '0;
            loc_gnt_reg    <= 1'b0;
            loc_rdata_reg  <= '0;
            loc_rvalid_reg <= 1'b0;
            tx_data_reg    <= '0;
            tx_valid_reg   <= 1'b0;
            src_reg        <= SRC_SPI;
            is_read_reg    <= 1'b0;
        end else begin
            ram_en_reg     <= ram_en_next;
            ram_we_reg     <= ram_we_next;
            ram_addr_reg   <= ram_addr_next;
            ram_wdata_reg  <= ram_wdata_next;
            loc_gnt_reg    <= loc_gnt_next;
            loc_rdata_reg  <= loc_rdata_next;
            loc_rvalid_reg <= loc_rvalid_next;
            tx_data_reg    <= tx_data_next;
            tx_valid_reg   <= tx_valid_next;
            src_reg        <= src_next;
            is_read_reg    <= is_read_next;
        end
    end

    assign ram_en       = ram_en_reg;
    assign ram_we       = ram_we_reg;
    assign ram_addr     = ram_addr_reg;
    assign ram_wdata    = ram_wdata_reg;
    assign loc_gnt      = loc_gnt_reg;
    assign loc_rdata    = loc_rdata_reg;
    assign loc_rvalid   = loc_rvalid_reg;
    assign spi_tx_data  = tx_data_reg;
    assign spi_tx_valid = tx_valid_reg;
    assign spi_err      = spi_err_reg;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Self-checking bench for spi_ram_arbiter: SPI command table, plus directed
// sequences for latency, contention, overrun, level hold, back-to-back local
// writes and reset during a read.
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] spi_rx_data;
    logic       spi_rx_valid;
    logic [7:0] spi_tx_data;
    logic       spi_tx_valid;
    logic       spi_err;
    logic       loc_req;
    logic       loc_we;
    logic [7:0] loc_addr;
    logic [7:0] loc_wdata;
    logic       loc_gnt;
    logic [7:0] loc_rdata;
    logic       loc_rvalid;
    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    always #5 clk = ~clk;

    spi_ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_rx_data  (spi_rx_data),
        .spi_rx_valid (spi_rx_valid),
        .spi_tx_data  (spi_tx_data),
        .spi_tx_valid (spi_tx_valid),
        .spi_err      (spi_err),
        .loc_req      (loc_req),
        .loc_we       (loc_we),
        .loc_addr     (loc_addr),
        .loc_wdata    (loc_wdata),
        .loc_gnt      (loc_gnt),
        .loc_rdata    (loc_rdata),
        .loc_rvalid   (loc_rvalid),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    // Behavioural single-port synchronous RAM with a preload port.
    logic [7:0] mem [256];
    int         wr_count = 0;
    logic       poke_en = 1'b0;
    logic [7:0] poke_addr = 8'h00;
    logic [7:0] poke_data = 8'h00;

    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                wr_count = wr_count + 1;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    int vectors = 0;
    int errors  = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {spi_tx_data, spi_tx_valid, spi_err, loc_gnt, loc_rdata, loc_rvalid,
                     ram_en, ram_we, ram_addr, ram_wdata}, 64'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        spi_rx_valid = 1'b0;
        loc_req = 1'b0;
        tick(3);
        check_all_zero("reset_outputs");
        rst = 1'b0;
        tick(1);
    endtask

    task automatic spi_send(input logic [9:0] word, input int hi, input int lo);
        spi_rx_data  = word;
        spi_rx_valid = 1'b1;
        tick(hi);
        spi_rx_valid = 1'b0;
        tick(lo);
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        tick(1);
        poke_en   = 1'b0;
    endtask

    typedef struct {
        logic [9:0] word;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t tbl[10];
    int   gnt_cyc[4];
    int   c0;
    int   k;

    initial begin
        spi_rx_data  = 10'h000;
        spi_rx_valid = 1'b0;
        loc_req      = 1'b0;
        loc_we       = 1'b0;
        loc_addr     = 8'h00;
        loc_wdata    = 8'h00;
        rst          = 1'b1;
        tick(1);

        // ---------- Table: SPI write then read, two addresses ----------
        tbl[0] = '{10'h03C, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{10'h1A5, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{10'h23C, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{10'h300, 1'b1, 8'hA5, 1'b0};
        tbl[4] = '{10'h010, 1'b0, 8'h00, 1'b0};
        tbl[5] = '{10'h15A, 1'b0, 8'h00, 1'b0};
        tbl[6] = '{10'h210, 1'b0, 8'h00, 1'b0};
        tbl[7] = '{10'h3FF, 1'b1, 8'h5A, 1'b0};
        tbl[8] = '{10'h23C, 1'b0, 8'h00, 1'b0};
        tbl[9] = '{10'h300, 1'b1, 8'hA5, 1'b0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            spi_send(tbl[i].word, 3, 3);
            check($sformatf("tbl%0d_tx_valid", i), 64'(spi_tx_valid), 64'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_err", i), 64'(spi_err), 64'(tbl[i].exp_err));
            if (tbl[i].exp_valid)
                check($sformatf("tbl%0d_tx_data", i), 64'(spi_tx_data), 64'(tbl[i].exp_data));
        end
        check("mem_3c", 64'(mem[8'h3C]), 64'hA5);
        check("mem_10", 64'(mem[8'h10]), 64'h5A);

        // ---------- SPI read latency and hold ----------
        spi_send(10'h23C, 3, 3);
        spi_rx_data = 10'h300; spi_rx_valid = 1'b1;           // edge at T
        tick(1); spi_rx_valid = 1'b0;
        tick(1);                                              // T+2
        check("lat_ram_en", 64'({ram_en, ram_we, ram_addr}), 64'({1'b1, 1'b0, 8'h3C}));
        tick(1);                                              // T+3
        check("lat_tx_valid_t3", 64'(spi_tx_valid), 64'h0);
        tick(1);                                              // T+4
        check("lat_tx_valid_t4", 64'(spi_tx_valid), 64'h1);
        check("lat_tx_data", 64'(spi_tx_data), 64'hA5);
        tick(5);
        check("hold_tx_valid", 64'(spi_tx_valid), 64'h1);
        spi_rx_data = 10'h000; spi_rx_valid = 1'b1;
        tick(1);
        check("clear_tx_valid", 64'(spi_tx_valid), 64'h0);
        spi_rx_valid = 1'b0;
        tick(3);

        // ---------- Contention: local wins (last grant SPI), then SPI ----------
        poke(8'h10, 8'h77);
        poke(8'h20, 8'h99);
        do_reset();
        spi_send(10'h220, 3, 3);
        spi_rx_data = 10'h300; spi_rx_valid = 1'b1;           // T
        tick(1);                                              // T+1
        spi_rx_valid = 1'b0;
        loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h10;
        tick(1);                                              // T+2
        check("cont_loc_gnt", 64'({loc_gnt, ram_en, ram_addr}), 64'({1'b1, 1'b1, 8'h10}));
        loc_req = 1'b0;
        tick(1);                                              // T+3
        check("cont_en_gap3", 64'(ram_en), 64'h0);
        tick(1);                                              // T+4
        check("cont_loc_rvalid", 64'({loc_rvalid, loc_rdata}), 64'({1'b1, 8'h77}));
        check("cont_en_gap4", 64'(ram_en), 64'h0);
        tick(1);                                              // T+5
        check("cont_spi_issue", 64'({ram_en, loc_gnt, ram_addr}), 64'({1'b1, 1'b0, 8'h20}));
        tick(2);                                              // T+7
        check("cont_spi_tx", 64'({spi_tx_valid, spi_tx_data}), 64'({1'b1, 8'h99}));
        tick(3);

        // ---------- Level hold: one write for a long valid ----------
        spi_send(10'h005, 3, 3);
        c0 = wr_count;
        spi_send(10'h1C3, 6, 4);
        check("hold_one_write", 64'(wr_count - c0), 64'd1);
        check("hold_no_err", 64'(spi_err), 64'h0);
        check("hold_mem", 64'(mem[8'h05]), 64'hC3);

        // ---------- Overrun with local traffic ahead of SPI ----------
        do_reset();
        spi_send(10'h050, 3, 3);
        c0 = wr_count;
        spi_rx_data = 10'h111; spi_rx_valid = 1'b1;           // T
        loc_req = 1'b1; loc_we = 1'b1; loc_addr = 8'h60; loc_wdata = 8'hEE;
        tick(1);                                              // T+1
        check("ovr_loc_gnt", 64'(loc_gnt), 64'h1);
        loc_req = 1'b0; spi_rx_valid = 1'b0;
        tick(1);                                              // T+2
        spi_rx_data = 10'h122; spi_rx_valid = 1'b1;
        tick(1);                                              // T+3
        spi_rx_valid = 1'b0;
        check("ovr_err_set", 64'(spi_err), 64'h1);
        check("ovr_spi_write", 64'({ram_en, ram_we, ram_addr, ram_wdata}),
              64'({1'b1, 1'b1, 8'h50, 8'h11}));
        tick(6);
        check("ovr_write_count", 64'(wr_count - c0), 64'd2);
        check("ovr_mem_50", 64'(mem[8'h50]), 64'h11);
        check("ovr_mem_60", 64'(mem[8'h60]), 64'hEE);
        spi_send(10'h250, 3, 3);
        spi_send(10'h300, 3, 3);
        check("ovr_readback", 64'({spi_tx_valid, spi_tx_data}), 64'({1'b1, 8'h11}));
        check("ovr_err_sticky", 64'(spi_err), 64'h1);

        // ---------- Back-to-back local writes ----------
        do_reset();
        c0 = wr_count;
        for (int i = 0; i < 4; i++) gnt_cyc[i] = -1;
        k = 0;
        loc_req = 1'b1; loc_we = 1'b1; loc_addr = 8'h00; loc_wdata = 8'hB0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick(1);
            if (loc_gnt && k < 4) begin
                gnt_cyc[k] = cyc;
                k++;
                if (k < 4) begin
                    loc_addr  = 8'(k);
                    loc_wdata = 8'hB0 + 8'(k);
                end else begin
                    loc_req = 1'b0;
                end
            end
        end
        loc_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b2b_gnt%0d_cycle", i), 64'(gnt_cyc[i]), 64'(2 * i + 1));
            check($sformatf("b2b_mem%0d", i), 64'(mem[8'(i)]), 64'(8'hB0 + 8'(i)));
        end
        check("b2b_write_count", 64'(wr_count - c0), 64'd4);

        // ---------- Reset during RD_WAIT of an SPI read ----------
        do_reset();
        spi_send(10'h23C, 3, 3);
        spi_rx_data = 10'h300; spi_rx_valid = 1'b1;           // T
        tick(1); spi_rx_valid = 1'b0;
        tick(2);                                              // T+3, RD_WAIT
        rst = 1'b1;
        tick(1);
        check_all_zero("rst_rdwait_outputs");
        rst = 1'b0;
        tick(4);
        check("rst_no_tx_valid", 64'(spi_tx_valid), 64'h0);
        spi_send(10'h23C, 3, 3);
        spi_send(10'h300, 3, 3);
        check("rst_recover_read", 64'({spi_tx_valid, spi_tx_data}), 64'({1'b1, 8'hA5}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
Controller that sits between the SPI slave's 10-bit command stream and a single-port synchronous RAM. It also shares that RAM with a second, local requester port. It decodes SPI commands (address load, write data, read data), holds the write and read address registers, and arbitrates RAM access round-robin between the SPI path and the local port. Read data is returned to the SPI slave as tx_data/tx_valid, or to the local port as rdata/rvalid.

Parameters:
ADDR_W, 8, RAM address width; the address is taken from spi_rx_data[7:0].
DATA_W, 8, RAM data width; must equal the SPI payload width of 8.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous reset, active-high.
spi_rx_data  in  10  SPI command word: [9:8] = opcode, [7:0] = payload.
spi_rx_valid  in  1  level from the SPI slave; stays high for several cycles per word.
spi_tx_data  out  8  read data returned to the SPI slave.
spi_tx_valid  out  1  read data valid, held until the next accepted SPI word.
spi_err  out  1  sticky flag: an SPI data command was dropped.
loc_req  in  1  local access request; held until granted.
loc_we  in  1  local write enable; 1 = write, 0 = read.
loc_addr  in  ADDR_W  local address.
loc_wdata  in  DATA_W  local write data.
loc_gnt  out  1  one-cycle pulse when the local access is issued to the RAM.
loc_rdata  out  DATA_W  local read data.
loc_rvalid  out  1  one-cycle pulse qualifying loc_rdata.
ram_en  out  1  RAM access strobe.
ram_we  out  1  RAM write enable.
ram_addr  out  ADDR_W  RAM address.
ram_wdata  out  DATA_W  RAM write data.
ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en with ram_we=0.

Behaviour:
- Reset: all outputs are 0. wr_addr, rd_addr, pending flags, last-grant bit and rx_valid history are 0. FSM goes to ARB.
- Reset mid-operation: an in-flight access is abandoned and no rvalid/tx_valid is produced. Pending SPI ops are dropped.
- SPI word acceptance is on the rising edge of spi_rx_valid only (high now, low last cycle). The held-high level never re-triggers.
- Decode on an accepted word at cycle T; effects are visible at T+1:
  - 00: wr_addr <= payload.
  - 01: pending write of payload to wr_addr.
  - 10: rd_addr <= payload.
  - 11: pending read from rd_addr; the payload is ignored.
- Every accepted word clears spi_tx_valid at T+1.
- Address commands never touch the RAM and never wait on arbitration.
- A data command (01/11) accepted while an SPI op is still pending is dropped and sets spi_err. The pending op is unchanged.
- spi_tx_data/spi_tx_valid are registered. Once set, they hold until the next accepted word or reset.
- FSM states:
  - ARB: if spi_pend and loc_req both request, grant the one not granted last; otherwise grant whichever requests. On a grant, register ram_en=1, ram_we, ram_addr, ram_wdata, and loc_gnt=1 if local; go to ISSUE. With no request, ram_en is 0.
  - ISSUE: ram_en is high for this one cycle. Clear the granted op (spi_pend, or the local request via loc_gnt). Update the last-grant bit. Go to RD_WAIT if this is a read, else ARB.
  - RD_WAIT: capture ram_rdata into spi_tx_data with spi_tx_valid=1 (SPI), or into loc_rdata with a loc_rvalid pulse (local). Values are visible next cycle. Go to ARB.
- Latency with an idle arbiter and no contention:
  - SPI read: rx_valid rising edge at T, spi_pend at T+1, ram_en at T+2, spi_tx_valid at T+4.
  - Local read: loc_req at N, loc_gnt and ram_en at N+1, loc_rvalid at N+3.
  - Write throughput is at most one per 2 cycles.
- When loc_req is low, the loc_* inputs are ignored. The local port must not change its inputs between req and gnt.
- An SPI edge arriving during ISSUE or RD_WAIT is accepted normally and becomes pending for the next ARB.

Decomposition:
- Package spi_ram_pkg holds the opcode constants (CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11), the FSM state encoding (ARB, ISSUE, RD_WAIT), and the grant-source encoding.
- One sub-module, rr_arb2: a 2-requester round-robin arbiter holding the last-grant bit, with grant outputs one-hot.

Test Plan:
- SPI write then read: send 00_0x3C, 01_0xA5, 10_0x3C, 11_xx. Required: RAM[0x3C]=0xA5, spi_tx_data=0xA5, spi_tx_valid 4 cycles after the 11 rx_valid edge, held until the next word.
- Level hold: spi_rx_valid high for 6 cycles on a 01 word. Required: exactly one RAM write.
- Contention: SPI read pending and loc_req read to 0x10 in the same cycle, last grant=SPI. Required: local granted first, SPI next. Both rdata values are correct, with no overlapping ram_en.
- Overrun: a 01 word followed by a second 01 word before the first is issued, with loc_req starving the SPI path. Required: the first value is written, the second is dropped, and spi_err=1 (sticky).
- Back-to-back local writes to 0x00..0x03. Required: a loc_gnt pulse every 2 cycles, and the RAM holds the 4 values.
- Reset asserted in RD_WAIT of an SPI read. Required: no spi_tx_valid, all outputs 0 the next cycle, and normal operation afterwards.
